// File: rtl/ham_pair_sequencer_if.sv
// Shared 8-bit data-memory port between the core and the Hamming pair sequencer.
// The sequencer is the master; the memory/arbiter side is the slave.
interface ham_pair_sequencer_if;
  logic       mem_req;
  logic       mem_gnt;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rdata
  );
endinterface

// File: rtl/ham_pair_sequencer.sv
// Walks all operand pairs (j<k) in data memory, tracks min/max Hamming distance
// and the pair that produced each, then writes both results back to memory.
module ham_pair_sequencer #(
  parameter int N_OPS     = 32,
  parameter int BASE_ADDR = 0,
  parameter int RES_ADDR  = 64,
  parameter int IW        = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  ham_pair_sequencer_if.master    mem,
  output logic [4:0]              min_dist,
  output logic [4:0]              max_dist,
  output logic [IW-1:0]           min_j,
  output logic [IW-1:0]           min_k,
  output logic [IW-1:0]           max_j,
  output logic [IW-1:0]           max_k
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LD_AHI = 4'd1;
  localparam logic [3:0] S_LD_ALO = 4'd2;
  localparam logic [3:0] S_LD_BHI = 4'd3;
  localparam logic [3:0] S_LD_BLO = 4'd4;
  localparam logic [3:0] S_CMP    = 4'd5;
  localparam logic [3:0] S_WR_MIN = 4'd6;
  localparam logic [3:0] S_WR_MAX = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam logic [IW-1:0] LAST_K = IW'(N_OPS - 1);
  localparam logic [IW-1:0] LAST_J = IW'(N_OPS - 2);

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  logic [3:0]    r_state;
  logic [IW-1:0] r_j, r_k;
  logic          r_rd_valid;
  logic [1:0]    r_rd_sel;
  logic          r_b_lo_ok;
  logic          r_first;
  logic [4:0]    r_min_dist, r_max_dist;
  logic [IW-1:0] r_min_j, r_min_k, r_max_j, r_max_k;
  logic [15:0]   r_a;
  logic [7:0]    r_b_hi, r_b_lo;

  logic          w_req, w_we, w_fire;
  logic [7:0]    w_addr, w_wdata;
  logic [1:0]    w_rd_sel;
  logic          w_blo_now, w_b_ready;
  logic [15:0]   w_b;
  logic [4:0]    w_dist;

  always_comb begin
    w_req    = 1'b0;
    w_we     = 1'b0;
    w_addr   = 8'd0;
    w_wdata  = 8'd0;
    w_rd_sel = 2'd0;
    case (r_state)
      S_LD_AHI: begin w_req = 1'b1; w_rd_sel = 2'd0; w_addr = 8'(BASE_ADDR + 2*int'(r_j));     end
      S_LD_ALO: begin w_req = 1'b1; w_rd_sel = 2'd1; w_addr = 8'(BASE_ADDR + 2*int'(r_j) + 1); end
      S_LD_BHI: begin w_req = 1'b1; w_rd_sel = 2'd2; w_addr = 8'(BASE_ADDR + 2*int'(r_k));     end
      S_LD_BLO: begin w_req = 1'b1; w_rd_sel = 2'd3; w_addr = 8'(BASE_ADDR + 2*int'(r_k) + 1); end
      S_WR_MIN: begin w_req = 1'b1; w_we = 1'b1; w_addr = 8'(RES_ADDR);     w_wdata = {3'b000, r_min_dist}; end
      S_WR_MAX: begin w_req = 1'b1; w_we = 1'b1; w_addr = 8'(RES_ADDR + 1); w_wdata = {3'b000, r_max_dist}; end
      default: ;
    endcase
  end

  assign w_fire = w_req && mem.mem_gnt;

  // The B low byte arrives in the CMP cycle itself, so compare against it directly
  // while it is being latched instead of spending an extra cycle.
  assign w_blo_now = r_rd_valid && (r_rd_sel == 2'd3);
  assign w_b_ready = w_blo_now || r_b_lo_ok;
  assign w_b       = {r_b_hi, w_blo_now ? mem.mem_rdata : r_b_lo};
  assign w_dist    = popcount16(r_a ^ w_b);

  // Read data capture: one byte per granted read, one cycle later
  always_ff @(posedge clk) begin
    if (r_rd_valid) begin
      case (r_rd_sel)
        2'd0:    r_a[15:8] <= mem.mem_rdata;
        2'd1:    r_a[7:0]  <= mem.mem_rdata;
        2'd2:    r_b_hi    <= mem.mem_rdata;
        default: r_b_lo    <= mem.mem_rdata;
      endcase
    end
  end

  // Control: FSM, pair indices, running min/max
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_j        <= '0;
      r_k        <= '0;
      r_rd_valid <= 1'b0;
      r_rd_sel   <= 2'd0;
      r_b_lo_ok  <= 1'b0;
      r_first    <= 1'b0;
      r_min_dist <= 5'd16;
      r_max_dist <= 5'd0;
      r_min_j    <= '0;
      r_min_k    <= '0;
      r_max_j    <= '0;
      r_max_k    <= '0;
    end else begin
      r_rd_valid <= w_fire && !w_we;
      r_rd_sel   <= w_rd_sel;
      if (w_blo_now) r_b_lo_ok <= 1'b1;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_LD_AHI;
            r_j        <= '0;
            r_k        <= IW'(1);
            r_first    <= 1'b1;
            r_min_dist <= 5'd16;
            r_max_dist <= 5'd0;
            r_min_j    <= '0;
            r_min_k    <= '0;
            r_max_j    <= '0;
            r_max_k    <= '0;
          end
        end
        S_LD_AHI: if (w_fire) r_state <= S_LD_ALO;
        S_LD_ALO: if (w_fire) r_state <= S_LD_BHI;
        S_LD_BHI: if (w_fire) r_state <= S_LD_BLO;
        S_LD_BLO: if (w_fire) begin
          r_state   <= S_CMP;
          r_b_lo_ok <= 1'b0;
        end
        S_CMP: begin
          if (w_b_ready) begin
            // Pair (0,1) always seeds both trackers so ties resolve to the first pair.
            if (r_first || (w_dist < r_min_dist)) begin
              r_min_dist <= w_dist;
              r_min_j    <= r_j;
              r_min_k    <= r_k;
            end
            if (r_first || (w_dist > r_max_dist)) begin
              r_max_dist <= w_dist;
              r_max_j    <= r_j;
              r_max_k    <= r_k;
            end
            r_first <= 1'b0;
            if (r_k < LAST_K) begin
              r_k     <= r_k + IW'(1);
              r_state <= S_LD_BHI;
            end else if (r_j < LAST_J) begin
              r_j     <= r_j + IW'(1);
              r_k     <= r_j + IW'(2);
              r_state <= S_LD_AHI;
            end else begin
              r_state <= S_WR_MIN;
            end
          end
        end
        S_WR_MIN: if (w_fire) r_state <= S_WR_MAX;
        S_WR_MAX: if (w_fire) r_state <= S_DONE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_req   = w_req;
  assign mem.mem_we    = w_we;
  assign mem.mem_addr  = w_addr;
  assign mem.mem_wdata = w_wdata;

  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done     = (r_state == S_DONE);
  assign min_dist = r_min_dist;
  assign max_dist = r_max_dist;
  assign min_j    = r_min_j;
  assign min_k    = r_min_k;
  assign max_j    = r_max_j;
  assign max_k    = r_max_k;

endmodule
